axi_rw_arbiter: RTL

Two-requester arbiter that shares the single AXI read/write master port between instruction fetch (IF, read-only) and the memory stage (MEM, read or write). It sits between the pipeline and the AXI master wrapper. It grants one requester at a time using round-robin on conflict, latches the granted request, and drives it downstream. It then routes the completion and read data back to the granted requester as a registered one-cycle ready pulse.

---
 rtl/axi_rw_arbiter_pkg.sv | 22 ++
 rtl/axi_rw_arbiter_rr_arb2.sv | 25 ++
 rtl/axi_rw_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/axi_rw_arbiter_pkg.sv
// Shared types for the IF/MEM read-write arbiter: FSM states, grant encoding
// and a small helper that flips a grant to the other requester.
package axi_rw_arbiter_pkg;

    localparam int unsigned SIZE_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        GNT_IF  = 1'b0,
        GNT_MEM = 1'b1
    } grant_e;

    function automatic grant_e other_grant(input grant_e g);
        return (g == GNT_IF) ? GNT_MEM : GNT_IF;
    endfunction

endpackage

// File: rtl/axi_rw_arbiter_rr_arb2.sv
// Two-input round-robin picker. req_i[0] is IF, req_i[1] is MEM. On a
// conflict the requester that did not win last time is chosen. Purely
// combinational; the caller decides when the pick is acted upon.
module rr_arb2
    import axi_rw_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  grant_e     last_grant_i,
    output grant_e     grant_o,
    output logic       valid_o
);

    // Choose the single requester, or alternate against last_grant on a conflict
    always_comb begin
        grant_o = GNT_IF;
        valid_o = |req_i;
        case (req_i)
            2'b01:   grant_o = GNT_IF;
            2'b10:   grant_o = GNT_MEM;
            2'b11:   grant_o = other_grant(last_grant_i);
            default: grant_o = GNT_IF;
        endcase
    end

endmodule

// File: rtl/axi_rw_arbiter.sv
// Shares one downstream read/write port between instruction fetch (read-only)
// and the memory stage. A request is latched on grant, held on the rw_* port
// until the downstream completes, and the result is returned to the owner as
// a registered one-cycle ready pulse. Every output comes straight from a flop.
module axi_rw_arbiter
    import axi_rw_arbiter_pkg::*;
#(
    parameter int unsigned RW_DATA_WIDTH = 64,
    parameter int unsigned RW_ADDR_WIDTH = 32
) (
    input  logic                     clock,
    input  logic                     reset,

    input  logic                     if_valid_i,
    output logic                     if_ready_o,
    input  logic [RW_ADDR_WIDTH-1:0] if_addr_i,
    input  logic [SIZE_WIDTH-1:0]    if_size_i,
    output logic [RW_DATA_WIDTH-1:0] if_data_o,

    input  logic                     mem_valid_i,
    input  logic                     mem_we_i,
    output logic                     mem_ready_o,
    input  logic [RW_ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [SIZE_WIDTH-1:0]    mem_size_i,
    input  logic [RW_DATA_WIDTH-1:0] mem_w_data_i,
    output logic [RW_DATA_WIDTH-1:0] mem_data_o,

    output logic                     rw_valid_o,
    output logic                     rw_we_o,
    input  logic                     rw_ready_i,
    output logic [RW_ADDR_WIDTH-1:0] rw_addr_o,
    output logic [SIZE_WIDTH-1:0]    rw_size_o,
    output logic [RW_DATA_WIDTH-1:0] rw_w_data_o,
    input  logic [RW_DATA_WIDTH-1:0] rw_data_read_i
);

    arb_state_e                 state_q, state_d;
    grant_e                     grant_q, grant_d;
    grant_e                     last_grant_q, last_grant_d;
    grant_e                     pick;
    logic                       pick_valid;

    logic                       rw_valid_q, rw_valid_d;
    logic                       rw_we_q, rw_we_d;
    logic [RW_ADDR_WIDTH-1:0]   rw_addr_q, rw_addr_d;
    logic [SIZE_WIDTH-1:0]      rw_size_q, rw_size_d;
    logic [RW_DATA_WIDTH-1:0]   rw_w_data_q, rw_w_data_d;
    logic                       if_ready_q, if_ready_d;
    logic                       mem_ready_q, mem_ready_d;
    logic [RW_DATA_WIDTH-1:0]   if_data_q, if_data_d;
    logic [RW_DATA_WIDTH-1:0]   mem_data_q, mem_data_d;

    rr_arb2 u_rr_arb2 (
        .req_i        ({mem_valid_i, if_valid_i}),
        .last_grant_i (last_grant_q),
        .grant_o      (pick),
        .valid_o      (pick_valid)
    );

    // Next-state and output logic: grant in IDLE, wait for completion in BUSY,
    // pulse the owner's ready in RESP
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        rw_valid_d   = rw_valid_q;
        rw_we_d      = rw_we_q;
        rw_addr_d    = rw_addr_q;
        rw_size_d    = rw_size_q;
        rw_w_data_d  = rw_w_data_q;
        if_ready_d   = 1'b0;
        mem_ready_d  = 1'b0;
        if_data_d    = if_data_q;
        mem_data_d   = mem_data_q;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d      = pick;
                    last_grant_d = pick;
                    rw_valid_d   = 1'b1;
                    state_d      = BUSY;
                    if (pick == GNT_MEM) begin
                        rw_we_d     = mem_we_i;
                        rw_addr_d   = mem_addr_i;
                        rw_size_d   = mem_size_i;
                        rw_w_data_d = mem_w_data_i;
                    end else begin
                        rw_we_d     = 1'b0;
                        rw_addr_d   = if_addr_i;
                        rw_size_d   = if_size_i;
                        rw_w_data_d = '0;
                    end
                end
            end
            BUSY: begin
                if (rw_ready_i) begin
                    rw_valid_d = 1'b0;
                    state_d    = RESP;
                    if (grant_q == GNT_MEM) begin
                        mem_data_d  = rw_data_read_i;
                        mem_ready_d = 1'b1;
                    end else begin
                        if_data_d  = rw_data_read_i;
                        if_ready_d = 1'b1;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d    = IDLE;
                rw_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; MEM counts as last winner so IF takes the first conflict
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= GNT_IF;
            last_grant_q <= GNT_MEM;
            rw_valid_q   <= 1'b0;
            rw_we_q      <= 1'b0;
            rw_addr_q    <= '0;
            rw_size_q    <= '0;
            rw_w_data_q  <= '0;
            if_ready_q   <= 1'b0;
            mem_ready_q  <= 1'b0;
            if_data_q    <= '0;
            mem_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            rw_valid_q   <= rw_valid_d;
            rw_we_q      <= rw_we_d;
            rw_addr_q    <= rw_addr_d;
            rw_size_q    <= rw_size_d;
            rw_w_data_q  <= rw_w_data_d;
            if_ready_q   <= if_ready_d;
            mem_ready_q  <= mem_ready_d;
            if_data_q    <= if_data_d;
            mem_data_q   <= mem_data_d;
        end
    end

    assign rw_valid_o  = rw_valid_q;
    assign rw_we_o     = rw_we_q;
    assign rw_addr_o   = rw_addr_q;
    assign rw_size_o   = rw_size_q;
    assign rw_w_data_o = rw_w_data_q;
    assign if_ready_o  = if_ready_q;
    assign mem_ready_o = mem_ready_q;
    assign if_data_o   = if_data_q;
    assign mem_data_o  = mem_data_q;

endmodule
